box_cursor_ctrl: RTL and testbench

- Clocked cursor controller for the 5x5 box grid. Turns raw board buttons into single registered cursor moves.
- Per button: synchronises, debounces and edge-detects. Arbitrates between simultaneous presses, then wraps the cursor within the grid.
- Emits a one-cycle select pulse that carries the current box coordinates to the game logic.

---
 rtl/box_cursor_ctrl_if.sv | 28 ++
 rtl/box_cursor_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_box_cursor_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/box_cursor_ctrl_if.sv
// Button inputs and cursor/select outputs of the 5x5 box cursor controller.
// No latency of its own; it only groups wires.
// No backpressure: every output is a one-way registered level or pulse.
interface box_cursor_ctrl_if;
  logic       btnL;
  logic       btnR;
  logic       btnU;
  logic       btnD;
  logic       btnC;
  logic [2:0] box_row;
  logic [2:0] box_col;
  logic       move_valid;
  logic       sel_valid;
  logic [2:0] sel_row;
  logic [2:0] sel_col;

  // Board/bench side: drives raw buttons and observes the cursor.
  modport master (
    output btnL, btnR, btnU, btnD, btnC,
    input  box_row, box_col, move_valid, sel_valid, sel_row, sel_col
  );

  // Controller side.
  modport slave (
    input  btnL, btnR, btnU, btnD, btnC,
    output box_row, box_col, move_valid, sel_valid, sel_row, sel_col
  );
endinterface

// File: rtl/box_cursor_ctrl.sv
// Cursor controller: sync + debounce + edge-detect buttons, arbitrate L>R>U>D, wrap in grid.
// Latency: stable raw press -> cursor update DEBOUNCE_CYCLES+3 edges later; select pulse same cycle.
// No backpressure: losing same-cycle presses are dropped. Optional macro BOX_CURSOR_AUTO_REPEAT_EN.
module box_cursor_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int GRID_ROWS       = 5,
  parameter int GRID_COLS       = 5,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 15000000
) (
  input logic           clk,
  input logic           rst,
  box_cursor_ctrl_if.slave bus
);

  localparam int CW  = $clog2(DEBOUNCE_CYCLES);
  localparam int RCW = $clog2((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);

  // Reject parameter sets the counters and 3-bit coordinates cannot represent.
  if (DEBOUNCE_CYCLES < 2 || GRID_ROWS < 2 || GRID_ROWS > 8 || GRID_COLS < 2 || GRID_COLS > 8
      || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_param_check
    $error("box_cursor_ctrl: illegal parameter value");
  end

  // Button bit order: 0=L 1=R 2=U 3=D 4=C.
  logic [4:0]    raw;
  logic [4:0]    sync1, sync2;
  logic [4:0]    deb;
  logic [4:0]    press;
  logic [CW-1:0] cnt [5];

  logic       press_move;
  logic [1:0] press_dir;
  logic       move_req;
  logic [1:0] move_dir;
  logic [2:0] row_q, col_q, row_n, col_n;
  logic       move_q, sel_q;
  logic [2:0] sel_row_q, sel_col_q;

  assign raw = {bus.btnC, bus.btnD, bus.btnU, bus.btnR, bus.btnL};

  // Two-flop synchroniser for the asynchronous buttons.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debounce: level flips only after the synced level disagrees long enough; rising flip is the press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb   <= '0;
      press <= '0;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          deb[i]   <= sync2[i];
          press[i] <= sync2[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Fixed-priority pick among fresh direction presses.
  always_comb begin
    press_move = 1'b1;
    press_dir  = 2'd0;
    if (press[0])      press_dir = 2'd0;
    else if (press[1]) press_dir = 2'd1;
    else if (press[2]) press_dir = 2'd2;
    else if (press[3]) press_dir = 2'd3;
    else               press_move = 1'b0;
  end

`ifdef BOX_CURSOR_AUTO_REPEAT_EN
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rstate_t;

  rstate_t        rstate, rstate_n;
  logic [RCW-1:0] rcnt, rcnt_n;
  logic [1:0]     rdir, rdir_n;
  logic           rep_step;
  logic           held;

  assign held = deb[{1'b0, rdir}];

  // Repeat FSM state, counter and recorded direction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rstate <= IDLE;
      rcnt   <= '0;
      rdir   <= 2'd0;
    end else begin
      rstate <= rstate_n;
      rcnt   <= rcnt_n;
      rdir   <= rdir_n;
    end
  end

  // Repeat FSM next state; a fresh press always restarts the delay with its direction.
  always_comb begin
    rstate_n = rstate;
    rcnt_n   = rcnt + 1'b1;
    rdir_n   = rdir;
    rep_step = 1'b0;
    case (rstate)
      IDLE: rcnt_n = '0;
      DELAY: begin
        if (!held) begin
          rstate_n = IDLE;
          rcnt_n   = '0;
        end else if (rcnt == RCW'(REPEAT_DELAY - 1)) begin
          rep_step = 1'b1;
          rstate_n = REPEAT;
          rcnt_n   = '0;
        end
      end
      REPEAT: begin
        if (!held) begin
          rstate_n = IDLE;
          rcnt_n   = '0;
        end else if (rcnt == RCW'(REPEAT_PERIOD - 1)) begin
          rep_step = 1'b1;
          rcnt_n   = '0;
        end
      end
      default: begin
        rstate_n = IDLE;
        rcnt_n   = '0;
      end
    endcase
    if (press_move) begin
      rstate_n = DELAY;
      rdir_n   = press_dir;
      rcnt_n   = '0;
    end
  end

  assign move_req = press_move | rep_step;
  assign move_dir = press_move ? press_dir : rdir;
`else
  assign move_req = press_move;
  assign move_dir = press_dir;
`endif

  // Wrapped next cursor position; rows and columns move independently.
  always_comb begin
    row_n = row_q;
    col_n = col_q;
    if (move_req) begin
      case (move_dir)
        2'd0:    col_n = (col_q == 3'd0) ? 3'(GRID_COLS - 1) : col_q - 3'd1;
        2'd1:    col_n = (col_q == 3'(GRID_COLS - 1)) ? 3'd0 : col_q + 3'd1;
        2'd2:    row_n = (row_q == 3'd0) ? 3'(GRID_ROWS - 1) : row_q - 3'd1;
        default: row_n = (row_q == 3'(GRID_ROWS - 1)) ? 3'd0 : row_q + 3'd1;
      endcase
    end
  end

  // Registered cursor, move pulse, and select capture of the pre-move position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q     <= '0;
      col_q     <= '0;
      move_q    <= 1'b0;
      sel_q     <= 1'b0;
      sel_row_q <= '0;
      sel_col_q <= '0;
    end else begin
      row_q  <= row_n;
      col_q  <= col_n;
      move_q <= move_req;
      sel_q  <= press[4];
      if (press[4]) begin
        sel_row_q <= row_q;
        sel_col_q <= col_q;
      end
    end
  end

  assign bus.box_row    = row_q;
  assign bus.box_col    = col_q;
  assign bus.move_valid = move_q;
  assign bus.sel_valid  = sel_q;
  assign bus.sel_row    = sel_row_q;
  assign bus.sel_col    = sel_col_q;

endmodule

// File: tb/tb_box_cursor_ctrl.sv
// Directed bench for box_cursor_ctrl with DEBOUNCE_CYCLES=4, 5x5 grid, REPEAT_DELAY=20, REPEAT_PERIOD=8.
// A stable press moves the cursor on the 7th edge after the first sampling edge.
// Build with or without BOX_CURSOR_AUTO_REPEAT_EN; the hold test adapts its expectations.
module tb_box_cursor_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  box_cursor_ctrl_if bus ();

  box_cursor_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .GRID_ROWS(5),
    .GRID_COLS(5),
    .REPEAT_DELAY(20),
    .REPEAT_PERIOD(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mask bit order: 0=L 1=R 2=U 3=D 4=C
  task automatic set_btns(input logic [4:0] m);
    bus.btnL = m[0];
    bus.btnR = m[1];
    bus.btnU = m[2];
    bus.btnD = m[3];
    bus.btnC = m[4];
  endtask

  // Press, sample around the expected move edge, release and let debounce settle.
  task automatic do_press(input logic [4:0] m, output logic early, output logic mv_at,
                          output logic mv_after, output logic [2:0] row_at, output logic [2:0] col_at,
                          output logic sel_at, output logic [2:0] srow, output logic [2:0] scol,
                          output logic sel_after);
    set_btns(m);
    early = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (bus.move_valid || bus.sel_valid) early = 1'b1;
    end
    tick();
    mv_at  = bus.move_valid;
    row_at = bus.box_row;
    col_at = bus.box_col;
    sel_at = bus.sel_valid;
    srow   = bus.sel_row;
    scol   = bus.sel_col;
    tick();
    mv_after  = bus.move_valid;
    sel_after = bus.sel_valid;
    set_btns(5'b0);
    repeat (10) tick();
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({bus.box_row, bus.box_col, bus.move_valid, bus.sel_valid, bus.sel_row, bus.sel_col} !== 14'd0) begin
      bad++;
      $display("FAIL reset_state: got row=%0d col=%0d mv=%b sel=%b srow=%0d scol=%0d, want all 0",
               bus.box_row, bus.box_col, bus.move_valid, bus.sel_valid, bus.sel_row, bus.sel_col);
    end
    tick();
    tick();
    rst = 1'b0;
    repeat (3) tick();
    total++;
    if ({bus.box_row, bus.box_col, bus.move_valid} !== 7'd0) begin
      bad++;
      $display("FAIL idle_after_reset: got row=%0d col=%0d mv=%b, want 0 0 0",
               bus.box_row, bus.box_col, bus.move_valid);
    end
  endtask

  task automatic test_wrap();
    logic e, mv, mva, s, sa;
    logic [2:0] r, c, sr, sc;
    for (int i = 0; i < 5; i++) begin
      do_press(5'b00010, e, mv, mva, r, c, s, sr, sc, sa);
      total++;
      if (e !== 1'b0 || mv !== 1'b1 || mva !== 1'b0) begin
        bad++;
        $display("FAIL wrap_pulse%0d: early=%b at=%b after=%b, want 0 1 0", i, e, mv, mva);
      end
      total++;
      if (c !== 3'((i + 1) % 5) || r !== 3'd0) begin
        bad++;
        $display("FAIL wrap_col%0d: got row=%0d col=%0d, want row=0 col=%0d", i, r, c, (i + 1) % 5);
      end
    end
    do_press(5'b00100, e, mv, mva, r, c, s, sr, sc, sa);
    total++;
    if (mv !== 1'b1 || r !== 3'd4 || c !== 3'd0) begin
      bad++;
      $display("FAIL wrap_up: got mv=%b row=%0d col=%0d, want 1 4 0", mv, r, c);
    end
  endtask

  task automatic test_glitch();
    logic seen;
    seen = 1'b0;
    set_btns(5'b01000);
    repeat (3) tick();
    set_btns(5'b0);
    repeat (15) begin
      tick();
      if (bus.move_valid) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0 || bus.box_row !== 3'd4) begin
      bad++;
      $display("FAIL glitch_reject: got move seen=%b row=%0d, want 0 4", seen, bus.box_row);
    end
  endtask

  task automatic test_arbitration();
    logic e, mv, mva, s, sa;
    logic [2:0] r, c, sr, sc;
    do_press(5'b00100, e, mv, mva, r, c, s, sr, sc, sa);
    do_press(5'b00100, e, mv, mva, r, c, s, sr, sc, sa);
    do_press(5'b00010, e, mv, mva, r, c, s, sr, sc, sa);
    do_press(5'b00010, e, mv, mva, r, c, s, sr, sc, sa);
    total++;
    if (r !== 3'd2 || c !== 3'd2) begin
      bad++;
      $display("FAIL arb_setup: got row=%0d col=%0d, want 2 2", r, c);
    end
    do_press(5'b01001, e, mv, mva, r, c, s, sr, sc, sa);
    total++;
    if (e !== 1'b0 || mv !== 1'b1 || mva !== 1'b0 || r !== 3'd2 || c !== 3'd1) begin
      bad++;
      $display("FAIL arb_l_over_d: early=%b at=%b after=%b row=%0d col=%0d, want 0 1 0 2 1",
               e, mv, mva, r, c);
    end
    total++;
    if (bus.box_row !== 3'd2 || bus.box_col !== 3'd1) begin
      bad++;
      $display("FAIL arb_dropped: got row=%0d col=%0d, want 2 1", bus.box_row, bus.box_col);
    end
  endtask

  task automatic test_select();
    logic e, mv, mva, s, sa;
    logic [2:0] r, c, sr, sc;
    do_press(5'b01000, e, mv, mva, r, c, s, sr, sc, sa);
    for (int i = 0; i < 3; i++) do_press(5'b00010, e, mv, mva, r, c, s, sr, sc, sa);
    total++;
    if (r !== 3'd3 || c !== 3'd4) begin
      bad++;
      $display("FAIL sel_setup: got row=%0d col=%0d, want 3 4", r, c);
    end
    do_press(5'b10010, e, mv, mva, r, c, s, sr, sc, sa);
    total++;
    if (s !== 1'b1 || sr !== 3'd3 || sc !== 3'd4 || sa !== 1'b0) begin
      bad++;
      $display("FAIL sel_capture: sel=%b srow=%0d scol=%0d after=%b, want 1 3 4 0", s, sr, sc, sa);
    end
    total++;
    if (mv !== 1'b1 || r !== 3'd3 || c !== 3'd0) begin
      bad++;
      $display("FAIL sel_with_move: mv=%b row=%0d col=%0d, want 1 3 0", mv, r, c);
    end
  endtask

  task automatic test_reset_hold();
    logic early_move;
    set_btns(5'b00010);
    #3;
    rst = 1'b1;
    #1;
    total++;
    if (bus.box_row !== 3'd0 || bus.box_col !== 3'd0 || bus.move_valid !== 1'b0 || bus.sel_valid !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: row=%0d col=%0d mv=%b sel=%b, want 0 0 0 0",
               bus.box_row, bus.box_col, bus.move_valid, bus.sel_valid);
    end
    repeat (3) tick();
    #3;
    rst = 1'b0;
    early_move = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      if (bus.move_valid || bus.box_col !== 3'd0) early_move = 1'b1;
    end
    @(posedge clk);
    #1;
    total++;
    if (early_move !== 1'b0 || bus.box_col !== 3'd1 || bus.move_valid !== 1'b1) begin
      bad++;
      $display("FAIL reset_held_press: early=%b col=%0d mv=%b, want 0 1 1",
               early_move, bus.box_col, bus.move_valid);
    end
    set_btns(5'b0);
    repeat (12) tick();
  endtask

  task automatic test_hold();
    int times[$];
    int exp_times[$];
    logic early;
    early = 1'b0;
`ifdef BOX_CURSOR_AUTO_REPEAT_EN
    exp_times = '{20, 28, 36, 44, 52};
`endif
    set_btns(5'b00010);
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (bus.move_valid) early = 1'b1;
    end
    tick();
    total++;
    if (early !== 1'b0 || bus.move_valid !== 1'b1 || bus.box_col !== 3'd2) begin
      bad++;
      $display("FAIL hold_first: early=%b mv=%b col=%0d, want 0 1 2", early, bus.move_valid, bus.box_col);
    end
    for (int t = 1; t <= 80; t++) begin
      tick();
      if (bus.move_valid) times.push_back(t);
      if (t == 49) set_btns(5'b0);
    end
    total++;
    if (times.size() != exp_times.size()) begin
      bad++;
      $display("FAIL hold_count: got %0d extra moves, want %0d", times.size(), exp_times.size());
    end else begin
      for (int i = 0; i < times.size(); i++) begin
        total++;
        if (times[i] != exp_times[i]) begin
          bad++;
          $display("FAIL hold_time%0d: got +%0d, want +%0d", i, times[i], exp_times[i]);
        end
      end
    end
    total++;
    if (bus.box_col !== 3'((2 + exp_times.size()) % 5) || bus.box_row !== 3'd0) begin
      bad++;
      $display("FAIL hold_final: row=%0d col=%0d, want 0 %0d", bus.box_row, bus.box_col,
               (2 + exp_times.size()) % 5);
    end
  endtask

  initial begin
    set_btns(5'b0);
    test_reset();
    test_wrap();
    test_glitch();
    test_arbitration();
    test_select();
    test_reset_hold();
    test_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
